// File: rtl/chord_dispatcher.sv
// chord_dispatcher: walks a song ROM entry by entry and issues notes to the
// note player as one-cycle load pulses, with beat-timed advance entries,
// pause-in-place, song-change restart and voice-busy backpressure.
module chord_dispatcher #(
    parameter int SONG_BITS = 2,
    parameter int PTR_BITS  = 7
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          play,
    input  logic [SONG_BITS-1:0]          song,
    input  logic                          beat,
    input  logic [2:0]                    voice_busy,
    output logic [SONG_BITS+PTR_BITS-1:0] rom_addr,
    input  logic [15:0]                   rom_data,
    output logic [5:0]                    note_to_load,
    output logic [5:0]                    duration,
    output logic                          load_new_note,
    output logic                          playing,
    output logic                          song_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DATA,
        S_DISPATCH,
        S_ADVANCE,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [PTR_BITS-1:0]   ptr_q, ptr_d;
    logic [5:0]            cnt_q, cnt_d;
    logic [SONG_BITS-1:0]  song_q, song_d;
    logic [5:0]            pend_note_q, pend_note_d;
    logic [5:0]            pend_dur_q, pend_dur_d;
    logic [5:0]            note_q, note_d;
    logic [5:0]            dur_q, dur_d;

    logic                  fire;
    logic                  step;
    logic                  w_adv;
    logic [5:0]            w_note;
    logic [5:0]            w_dur;
    logic [2:0]            unused_rom_bits;

    // Split the ROM word into its fields; the low three bits carry nothing.
    always_comb begin
        w_adv           = rom_data[15];
        w_note          = rom_data[14:9];
        w_dur           = rom_data[8:3];
        unused_rom_bits = rom_data[2:0];
    end

    // Next-state logic; a song change overrides every other transition.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        song_d      = song;
        pend_note_d = pend_note_q;
        pend_dur_d  = pend_dur_q;
        note_d      = note_q;
        dur_d       = dur_q;
        fire        = 1'b0;
        step        = 1'b0;

        if (state_q != S_IDLE && song != song_q) begin
            state_d = S_IDLE;
            ptr_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    ptr_d = '0;
                    if (play) state_d = S_FETCH;
                end
                S_FETCH: state_d = S_DATA;
                S_DATA: begin
                    if (rom_data == 16'h0000) begin
                        state_d = S_DONE;
                    end else if (w_adv) begin
                        if (w_dur == 6'd0) begin
                            step = 1'b1;
                        end else begin
                            cnt_d   = w_dur;
                            state_d = S_ADVANCE;
                        end
                    end else if (w_note == 6'd0 || w_dur == 6'd0) begin
                        step = 1'b1;
                    end else begin
                        pend_note_d = w_note;
                        pend_dur_d  = w_dur;
                        state_d     = S_DISPATCH;
                    end
                end
                S_DISPATCH: begin
                    if (play && voice_busy != 3'b111) begin
                        fire   = 1'b1;
                        note_d = pend_note_q;
                        dur_d  = pend_dur_q;
                        step   = 1'b1;
                    end
                end
                S_ADVANCE: begin
                    if (beat && play) begin
                        cnt_d = cnt_q - 6'd1;
                        if (cnt_q == 6'd1) step = 1'b1;
                    end
                end
                S_DONE: begin
                    if (!play) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase

            // Pointer advance is shared by every entry-consuming path;
            // the last entry ends the song instead of wrapping.
            if (step) begin
                if (&ptr_q) begin
                    state_d = S_DONE;
                end else begin
                    ptr_d   = ptr_q + 1'b1;
                    state_d = S_FETCH;
                end
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            song_q      <= '0;
            pend_note_q <= '0;
            pend_dur_q  <= '0;
            note_q      <= '0;
            dur_q       <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            song_q      <= song_d;
            pend_note_q <= pend_note_d;
            pend_dur_q  <= pend_dur_d;
            note_q      <= note_d;
            dur_q       <= dur_d;
        end
    end

    // Outputs; note/duration show the pending entry only during its pulse.
    always_comb begin
        rom_addr      = {song_q, ptr_q};
        load_new_note = fire;
        note_to_load  = fire ? pend_note_q : note_q;
        duration      = fire ? pend_dur_q : dur_q;
        playing       = (state_q != S_IDLE) && (state_q != S_DONE);
        song_done     = (state_q == S_DONE);
    end

endmodule

// File: tb/tb_chord_dispatcher.sv
// Scoreboard bench for chord_dispatcher: a ROM model, directed timing
// scenarios and randomized songs; expected notes come from walking the ROM.
module tb_chord_dispatcher;

    logic        clk;
    logic        reset;
    logic        play;
    logic [1:0]  song;
    logic        beat;
    logic [2:0]  voice_busy;
    logic [8:0]  rom_addr;
    logic [15:0] rom_data;
    logic [5:0]  note_to_load;
    logic [5:0]  duration;
    logic        load_new_note;
    logic        playing;
    logic        song_done;

    logic [15:0] rom_mem [0:511];
    logic [11:0] exp_q [$];
    int          pulse_cyc [$];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    logic [11:0] mon_exp;

    chord_dispatcher #(.SONG_BITS(2), .PTR_BITS(7)) dut (
        .clk(clk), .reset(reset), .play(play), .song(song), .beat(beat),
        .voice_busy(voice_busy), .rom_addr(rom_addr), .rom_data(rom_data),
        .note_to_load(note_to_load), .duration(duration),
        .load_new_note(load_new_note), .playing(playing), .song_done(song_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // synchronous ROM, one cycle of read latency
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [15:0] mk(input logic adv, input int note, input int dur);
        return {adv, 6'(note), 6'(dur), 3'b000};
    endfunction

    function automatic int pc(input int i);
        if (i < pulse_cyc.size()) return pulse_cyc[i];
        return -1;
    endfunction

    // Reference: every playable note entry of the song, in order, until the
    // terminator or the end of the 128-entry table.
    task automatic push_model(input int s);
        logic [15:0] w;
        for (int i = 0; i < 128; i++) begin
            w = rom_mem[s*128 + i];
            if (w == 16'h0000) break;
            if (w[15]) continue;
            if (w[14:9] == 6'd0 || w[8:3] == 6'd0) continue;
            exp_q.push_back({w[14:9], w[8:3]});
        end
    endtask

    // Monitor: pops the scoreboard on every dispatch pulse.
    always @(negedge clk) begin
        if (reset && load_new_note) begin
            pulse_cyc.push_back(cyc);
            chk("pulse_gate", int'(play && voice_busy != 3'b111), 1);
            chk("pulse_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                chk("pulse_note", int'(note_to_load), int'(mon_exp[11:6]));
                chk("pulse_dur", int'(duration), int'(mon_exp[5:0]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int t);
        int n;
        n = 0;
        while (cyc < t && n < 2000) begin
            tick();
            n++;
        end
    endtask

    task automatic run_to_done(input int bound, input bit rnd, input string tag);
        int n;
        n = 0;
        while (n < bound) begin
            @(negedge clk);
            if (song_done) break;
            tick();
            n++;
            beat = ($urandom_range(0, 2) == 0);
            if (rnd) begin
                play = ($urandom_range(0, 9) != 0);
                voice_busy = ($urandom_range(0, 3) == 0) ? 3'b111 : 3'($urandom_range(0, 6));
            end
        end
        chk({tag, "_done"}, int'(song_done), 1);
        beat = 1'b0;
    endtask

    task automatic end_song();
        tick();
        play = 1'b0;
        voice_busy = 3'b000;
        beat = 1'b0;
        tick();
        tick();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rom_addr"}, int'(rom_addr), 0);
        chk({tag, "_note"}, int'(note_to_load), 0);
        chk({tag, "_dur"}, int'(duration), 0);
        chk({tag, "_load"}, int'(load_new_note), 0);
        chk({tag, "_playing"}, int'(playing), 0);
        chk({tag, "_done"}, int'(song_done), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int p;
        int seen;
        int wrapped;
        int s;
        int len;
        int r;
        logic [15:0] w;

        reset = 1'b1; play = 1'b0; song = 2'd0; beat = 1'b0; voice_busy = 3'b000;
        for (int i = 0; i < 512; i++) rom_mem[i] = '0;
        #1 reset = 1'b0;
        #1 check_zero("rst");
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // chord of three notes then an advance of two beats
        rom_mem[0] = mk(0, 44, 6); rom_mem[1] = mk(0, 48, 6);
        rom_mem[2] = mk(0, 51, 6); rom_mem[3] = mk(1, 0, 2); rom_mem[4] = '0;
        pulse_cyc.delete(); push_model(0);
        song = 2'd0; play = 1'b1; p = cyc;
        goto(p+11); beat = 1'b1;          // entry-cycle beat, not counted
        goto(p+12); beat = 1'b0;
        goto(p+14); beat = 1'b1;
        goto(p+15); beat = 1'b0;
        goto(p+17); beat = 1'b1;
        @(negedge clk); chk("a_addr_wait", int'(rom_addr), 3);
        goto(p+18); beat = 1'b0;
        @(negedge clk); chk("a_addr_next", int'(rom_addr), 4);
        goto(p+19); @(negedge clk); chk("a_done_early", int'(song_done), 0);
        goto(p+20); @(negedge clk); chk("a_done", int'(song_done), 1);
        chk("a_pulse0", pc(0), p+3);
        chk("a_pulse1", pc(1), p+6);
        chk("a_pulse2", pc(2), p+9);
        chk("a_hold_note", int'(note_to_load), 51);
        chk("a_drained", exp_q.size(), 0);
        end_song();

        // all voices busy for 20 cycles in DISPATCH
        pulse_cyc.delete(); push_model(0);
        voice_busy = 3'b111; play = 1'b1; p = cyc;
        goto(p+23); voice_busy = 3'b011;
        run_to_done(300, 0, "b");
        chk("b_pulse_release", pc(0), p+23);
        chk("b_drained", exp_q.size(), 0);
        end_song();

        // pause during an advance of four beats
        rom_mem[256] = mk(1, 0, 4); rom_mem[257] = mk(0, 30, 5); rom_mem[258] = '0;
        pulse_cyc.delete(); push_model(2);
        song = 2'd2; play = 1'b1; p = cyc;
        goto(p+5); beat = 1'b1;
        goto(p+6); beat = 1'b0;
        goto(p+7); play = 1'b0;
        for (int k = 0; k < 5; k++) begin
            goto(p+8+2*k); beat = 1'b1;
            goto(p+9+2*k); beat = 1'b0;
        end
        goto(p+21); play = 1'b1;
        goto(p+23); beat = 1'b1;
        goto(p+24); beat = 1'b0;
        goto(p+25); beat = 1'b1;
        goto(p+26); beat = 1'b0;
        goto(p+27); beat = 1'b1;
        @(negedge clk); chk("c_addr_wait", int'(rom_addr), 256);
        goto(p+28); beat = 1'b0;
        @(negedge clk); chk("c_addr_next", int'(rom_addr), 257);
        run_to_done(300, 0, "c");
        chk("c_pulse0", pc(0), p+30);
        chk("c_drained", exp_q.size(), 0);
        end_song();

        // song change during ADVANCE
        rom_mem[384] = mk(1, 0, 10); rom_mem[385] = mk(0, 20, 3); rom_mem[386] = '0;
        rom_mem[128] = mk(0, 33, 7); rom_mem[129] = '0;
        pulse_cyc.delete(); push_model(1);
        song = 2'd3; play = 1'b1; p = cyc;
        goto(p+5); song = 2'd1;
        goto(p+6); @(negedge clk); chk("d_idle", int'(playing), 0);
        goto(p+7); @(negedge clk);
        chk("d_restart_addr", int'(rom_addr), 128);
        chk("d_playing", int'(playing), 1);
        run_to_done(300, 0, "d");
        chk("d_pulse0", pc(0), p+9);
        chk("d_pulse_count", pulse_cyc.size(), 1);
        chk("d_drained", exp_q.size(), 0);
        chk("d_hold_note", int'(note_to_load), 33);
        chk("d_hold_dur", int'(duration), 7);
        end_song();

        // asynchronous reset while waiting in DISPATCH
        voice_busy = 3'b111; play = 1'b1; p = cyc;
        goto(p+5);
        chk("f_pre_playing", int'(playing), 1);
        chk("f_pre_note", int'(note_to_load), 33);
        #2 reset = 1'b0;
        #1 check_zero("f_async");
        tick(); tick();
        exp_q.delete(); pulse_cyc.delete(); push_model(1);
        voice_busy = 3'b000; reset = 1'b1; p = cyc;
        goto(p+1); @(negedge clk); chk("f_restart_addr", int'(rom_addr), 128);
        run_to_done(300, 0, "f");
        chk("f_pulse0", pc(0), p+3);
        chk("f_drained", exp_q.size(), 0);
        end_song();

        // full 128-entry song, leading rest, one zero-duration skip
        for (int i = 0; i < 128; i++)
            rom_mem[256+i] = mk(0, ((i*7) % 63) + 1, (i % 9) + 1);
        rom_mem[256] = mk(0, 0, 6);
        rom_mem[261] = mk(0, 12, 0);
        pulse_cyc.delete(); exp_q.delete(); push_model(2);
        song = 2'd2; play = 1'b1; p = cyc;
        goto(p+2);
        seen = 0; wrapped = 0;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            if (int'(rom_addr) != 256) seen = 1;
            else if (seen != 0) wrapped = 1;
            if (song_done) break;
            tick();
        end
        chk("e_done", int'(song_done), 1);
        chk("e_addr_end", int'(rom_addr), 383);
        chk("e_no_wrap", wrapped, 0);
        chk("e_pulse0", pc(0), p+5);
        chk("e_drained", exp_q.size(), 0);
        end_song();

        // randomized songs with random beats, pauses and busy voices
        for (int it = 0; it < 8; it++) begin
            s = $urandom_range(0, 3);
            for (int i = 0; i < 128; i++) rom_mem[s*128+i] = '0;
            len = $urandom_range(3, 20);
            for (int i = 0; i < len; i++) begin
                r = $urandom_range(0, 9);
                if (r < 6)      w = mk(0, $urandom_range(0, 63), $urandom_range(0, 12));
                else if (r < 8) w = mk(1, $urandom_range(0, 63), $urandom_range(0, 3));
                else            w = mk(0, 0, $urandom_range(0, 63));
                w[2:0] = 3'($urandom_range(0, 7));
                rom_mem[s*128+i] = w;
            end
            exp_q.delete(); pulse_cyc.delete(); push_model(s);
            song = 2'(s); play = 1'b1;
            run_to_done(4000, 1, "rnd");
            chk("rnd_drained", exp_q.size(), 0);
            end_song();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
